// File: rtl/i2c_bus_condition_gen_if.sv
// Command and pad-level bundle between the I2C master control FSM and the
// START / repeated-START / STOP condition generator.
interface i2c_bus_condition_gen_if;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_ready;
   logic       scl_in;
   logic       sda_in;
   logic       scl_en;
   logic       sda_en;
   logic       busy;
   logic       complete;
   logic       error;

   // master: control FSM plus pad inputs; slave: the condition generator
   modport master (
      output cmd_valid, cmd, scl_in, sda_in,
      input  cmd_ready, scl_en, sda_en, busy, complete, error
   );

   modport slave (
      input  cmd_valid, cmd, scl_in, sda_in,
      output cmd_ready, scl_en, sda_en, busy, complete, error
   );
endinterface

// File: rtl/i2c_bus_condition_gen.sv
// I2C master bus-condition generator: drives START, repeated START and STOP on
// the open-drain enables, watching the synchronised pads for stretching and faults.
module i2c_bus_condition_gen #(
   parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
   parameter int unsigned SCL_FREQ_HZ    = 100_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000,
   parameter int unsigned CNT_W          = 17
) (
   input logic                      clk,
   input logic                      reset,
   i2c_bus_condition_gen_if.slave   bus_if
);

   localparam int unsigned      HALF      = CLK_FREQ_HZ / (2 * SCL_FREQ_HZ);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SCL_RISE, S_HIGH_HOLD, S_SDA_EDGE, S_SCL_FALL, S_DONE, S_ERROR
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [1:0]       scl_sync_q, sda_sync_q;
   logic             scl_en_q, scl_en_d;
   logic             sda_en_q, sda_en_d;
   logic             complete_q, complete_d;
   logic             error_q, error_d;

   logic scl_s, sda_s, hold_last;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign hold_last = (cnt_q == HALF_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cmd_q      <= CMD_START;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_en_q   <= 1'b1;
         sda_en_q   <= 1'b1;
         complete_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         scl_sync_q <= {scl_sync_q[0], bus_if.scl_in};
         sda_sync_q <= {sda_sync_q[0], bus_if.sda_in};
         scl_en_q   <= scl_en_d;
         sda_en_q   <= sda_en_d;
         complete_q <= complete_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      case (state_q)
         S_IDLE: begin
            if (bus_if.cmd_valid) begin
               cmd_d = bus_if.cmd;
               case (bus_if.cmd)
                  2'b00:        state_d = S_SCL_RISE;
                  2'b01, 2'b10: state_d = S_SETUP;
                  default:      state_d = S_ERROR;
               endcase
            end
         end
         S_SETUP:     if (hold_last) state_d = S_SCL_RISE;
         S_SCL_RISE: begin
            // A START additionally needs SDA free, otherwise the bus is taken
            if (scl_s && (sda_s || (cmd_q != CMD_START))) state_d = S_HIGH_HOLD;
            else if (cnt_q == TO_LAST)                    state_d = S_ERROR;
         end
         S_HIGH_HOLD: begin
            if (!scl_s)                 state_d = S_ERROR;
            else if (hold_last) state_d = (sda_s != sda_en_q) ? S_ERROR : S_SDA_EDGE;
         end
         S_SDA_EDGE: begin
            if (hold_last) begin
               if (cmd_q == CMD_STOP) state_d = sda_s ? S_DONE : S_ERROR;
               else                   state_d = S_SCL_FALL;
            end
         end
         S_SCL_FALL:  if (hold_last) state_d = S_DONE;
         default:     state_d = S_IDLE;
      endcase

      cnt_d = ((state_d != state_q) || (state_d == S_IDLE)) ? '0 : cnt_q + 1'b1;

      // Line levels follow the state being entered, so they register with it
      scl_en_d = scl_en_q;
      sda_en_d = sda_en_q;
      case (state_d)
         S_SETUP: begin
            scl_en_d = 1'b0;
            sda_en_d = (cmd_d != CMD_STOP);
         end
         S_SCL_RISE: begin
            scl_en_d = 1'b1;
            if (cmd_d == CMD_START) sda_en_d = 1'b1;
         end
         S_SDA_EDGE: sda_en_d = (cmd_d == CMD_STOP);
         S_SCL_FALL: scl_en_d = 1'b0;
         S_ERROR: begin
            scl_en_d = 1'b1;
            sda_en_d = 1'b1;
         end
         default: ;
      endcase

      complete_d = (state_d == S_DONE) || (state_d == S_ERROR);
      error_d    = (state_d == S_ERROR);
   end

   assign bus_if.cmd_ready = (state_q == S_IDLE);
   assign bus_if.busy      = (state_q != S_IDLE);
   assign bus_if.scl_en    = scl_en_q;
   assign bus_if.sda_en    = sda_en_q;
   assign bus_if.complete  = complete_q;
   assign bus_if.error     = error_q;

endmodule
